// File: rtl/scfifo_s_m20k_core_pkg.sv
// Shared constants and elaboration-time parameter checks for the M20K-based
// single-clock FIFO.
package scfifo_s_m20k_core_pkg;

  // Maximum number of stored words; one slot stays free so the pointers
  // never alias.
  function automatic int fifo_depth(input int log_depth);
    return (1 << log_depth) - 1;
  endfunction

  function automatic bit params_ok(input int log_depth, input int width,
                                   input int af_value, input int ae_value,
                                   input int show_ahead, input int out_reg);
    return (log_depth > 3) && (log_depth < 12) && (width > 0) &&
           (af_value > 0) && (af_value < (1 << log_depth)) &&
           (ae_value > 0) && (ae_value < (1 << log_depth)) &&
           (show_ahead inside {0, 1}) && (out_reg inside {0, 1});
  endfunction

endpackage

// File: rtl/m20k_sdp_ram.sv
// Simple dual-port RAM intended for M20K: one write port and a registered,
// enabled read port whose output register has async and sync clears.
module m20k_sdp_ram #(
  parameter int WIDTH     = 20,
  parameter int LOG_DEPTH = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [LOG_DEPTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [LOG_DEPTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  (* ramstyle = "M20K, no_rw_check" *)
  logic [WIDTH-1:0] mem_q [0:(2**LOG_DEPTH)-1];
  logic [WIDTH-1:0] rd_data_q;

  // NOTE: the array has no reset so it can map onto block RAM; only the read
  // register is cleared. Sequential state uses non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/scfifo_s_m20k_core.sv
// Single-clock FIFO on an M20K RAM with normal or show-ahead read, optional
// output register and registered status flags.
module scfifo_s_m20k_core
  import scfifo_s_m20k_core_pkg::*;
#(
  parameter int    LOG_DEPTH          = 9,
  parameter int    WIDTH              = 20,
  parameter int    ALMOST_FULL_VALUE  = 510,
  parameter int    ALMOST_EMPTY_VALUE = 2,
  parameter int    SHOW_AHEAD         = 0,
  parameter int    OUTPUT_REGISTER    = 0,
  parameter string FAMILY             = "S10"
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic [WIDTH-1:0]     data,
  input  logic                 wrreq,
  input  logic                 rdreq,
  output logic [WIDTH-1:0]     q,
  output logic [LOG_DEPTH-1:0] usedw,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full
);

  if (!params_ok(LOG_DEPTH, WIDTH, ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE,
                 SHOW_AHEAD, OUTPUT_REGISTER)) begin : g_param_err
    $error("scfifo_s_m20k_core: parameter out of range");
  end
  if (FAMILY != "Agilex" && FAMILY != "S10" && FAMILY != "Other") begin : g_family_err
    $error("scfifo_s_m20k_core: FAMILY must be Agilex, S10 or Other");
  end

  typedef logic [LOG_DEPTH-1:0] ptr_t;
  localparam ptr_t MAX_USED = ptr_t'(fifo_depth(LOG_DEPTH));
  localparam ptr_t AF_THR   = ptr_t'(ALMOST_FULL_VALUE);
  localparam ptr_t AE_THR   = ptr_t'(ALMOST_EMPTY_VALUE);
  localparam ptr_t ONE      = ptr_t'(1);

  ptr_t wr_ptr_q, rd_ptr_q, used_q, used_d;
  logic empty_q, full_q, aempty_q, afull_q;
  logic wr_acc, rd_acc, rd_en, empty_d;
  logic [WIDTH-1:0] ram_q;

  assign wr_acc = wrreq & ~full_q & ~sclr;
  assign rd_acc = rdreq & ~empty_q & ~sclr;

  always_comb begin
    // NOTE: default first so every path assigns used_d and no latch appears.
    used_d = used_q;
    case ({wr_acc, rd_acc})
      2'b10:   used_d = used_q + ONE;
      2'b01:   used_d = used_q - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + ptr_t'(wr_acc);
      rd_ptr_q <= rd_ptr_q + ptr_t'(rd_en);
      used_q   <= used_d;
      empty_q  <= empty_d;
      full_q   <= (used_d == MAX_USED);
      aempty_q <= (used_d < AE_THR);
      afull_q  <= (used_d >= AF_THR);
    end
  end

  if (SHOW_AHEAD == 0) begin : g_normal
    assign rd_en   = rd_acc;
    assign empty_d = (used_d == '0);
    if (OUTPUT_REGISTER == 0) begin : g_direct
      assign q = ram_q;
    end else begin : g_oreg
      logic             rd_vld_q;
      logic [WIDTH-1:0] q_q;
      always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
          rd_vld_q <= 1'b0;
          q_q      <= '0;
        end else if (sclr) begin
          rd_vld_q <= 1'b0;
          q_q      <= '0;
        end else begin
          rd_vld_q <= rd_en;
          if (rd_vld_q) q_q <= ram_q;
        end
      end
      assign q = q_q;
    end
  end else begin : g_show_ahead
    // rd_ptr_q is the fetch pointer: words between it and wr_ptr_q are still
    // in the RAM, fetched words sit in the prefetch stage(s).
    logic ram_ne;
    assign ram_ne = (wr_ptr_q != rd_ptr_q);
    if (OUTPUT_REGISTER == 0) begin : g_direct
      assign rd_en   = ram_ne & (empty_q | rd_acc) & ~sclr;
      assign empty_d = ~(rd_en | (~empty_q & ~rd_acc));
      assign q       = ram_q;
    end else begin : g_oreg
      logic             s1_vld_q, s2_load;
      logic [WIDTH-1:0] q_q;
      assign s2_load = s1_vld_q & (empty_q | rd_acc);
      assign rd_en   = ram_ne & (~s1_vld_q | s2_load) & ~sclr;
      assign empty_d = ~(s2_load | (~empty_q & ~rd_acc));
      always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
          s1_vld_q <= 1'b0;
          q_q      <= '0;
        end else if (sclr) begin
          s1_vld_q <= 1'b0;
          q_q      <= '0;
        end else begin
          s1_vld_q <= rd_en | (s1_vld_q & ~s2_load);
          if (s2_load) q_q <= ram_q;
        end
      end
      assign q = q_q;
    end
  end

  m20k_sdp_ram #(
    .WIDTH    (WIDTH),
    .LOG_DEPTH(LOG_DEPTH)
  ) u_ram (
    .clk_i    (clock),
    .rst_ni   (aclr),
    .clr_i    (sclr),
    .wr_en_i  (wr_acc),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(ram_q)
  );

  assign usedw        = used_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;

endmodule

// File: tb/tb_scfifo_s_m20k_core.sv
// Drives a normal-read and a show-ahead FIFO with shared stimulus and checks
// both against queue-based models every cycle, plus directed literal checks.
module tb_scfifo_s_m20k_core;

  localparam int LD    = 4;
  localparam int W     = 20;
  localparam int DEPTH = 15;

  logic         clock = 1'b0;
  logic         aclr  = 1'b1;
  logic         sclr  = 1'b0;
  logic         wrreq = 1'b0;
  logic         rdreq = 1'b0;
  logic [W-1:0] data  = '0;

  logic [W-1:0]  q_n, q_s;
  logic [LD-1:0] usedw_n, usedw_s;
  logic          empty_n, full_n, ae_n, af_n;
  logic          empty_s, full_s, ae_s, af_s;

  always #5 clock = ~clock;

  scfifo_s_m20k_core #(
    .LOG_DEPTH(LD), .WIDTH(W), .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(2),
    .SHOW_AHEAD(0), .OUTPUT_REGISTER(0), .FAMILY("S10")
  ) dut_n (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq),
    .rdreq(rdreq), .q(q_n), .usedw(usedw_n), .empty(empty_n), .full(full_n),
    .almost_empty(ae_n), .almost_full(af_n)
  );

  scfifo_s_m20k_core #(
    .LOG_DEPTH(LD), .WIDTH(W), .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(2),
    .SHOW_AHEAD(1), .OUTPUT_REGISTER(0), .FAMILY("Agilex")
  ) dut_s (
    .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq),
    .rdreq(rdreq), .q(q_s), .usedw(usedw_s), .empty(empty_s), .full(full_s),
    .almost_empty(ae_s), .almost_full(af_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference models: plain word queues. The show-ahead model records the
  // cycle each word was written so it can tell when the next word must show.
  typedef struct {
    logic [W-1:0] d;
    int unsigned  wc;
  } sa_word_t;

  logic [W-1:0] mn[$];
  logic [W-1:0] qn_exp;
  bit           qn_known = 1'b0;
  sa_word_t     ms[$];
  int           stall = 0;
  bit           must_show = 1'b0;
  int unsigned  cyc_cnt = 0;

  always @(negedge clock) begin : model
    bit wn, rn, ws, rs;
    cyc_cnt++;
    if (!aclr) begin
      mn.delete();
      ms.delete();
      qn_known  = 1'b0;
      must_show = 1'b0;
      stall     = 0;
    end

    check("n_usedw", usedw_n, mn.size());
    check("n_empty", empty_n, mn.size() == 0);
    check("n_full", full_n, mn.size() == DEPTH);
    check("n_almost_empty", ae_n, mn.size() < 2);
    check("n_almost_full", af_n, mn.size() >= 12);
    if (qn_known) check("n_q", q_n, qn_exp);

    check("s_usedw", usedw_s, ms.size());
    check("s_full", full_s, ms.size() == DEPTH);
    check("s_almost_empty", ae_s, ms.size() < 2);
    check("s_almost_full", af_s, ms.size() >= 12);
    if (ms.size() == 0) check("s_empty_when_none", empty_s, 1);
    if (!empty_s && ms.size() > 0) check("s_q_head", q_s, ms[0].d);
    if (ms.size() > 0 && empty_s) stall++;
    else stall = 0;
    check("s_fill_latency", stall <= 3, 1);
    if (must_show) check("s_next_word", empty_s, 0);

    if (aclr) begin
      if (sclr) begin
        mn.delete();
        ms.delete();
        qn_known  = 1'b0;
        must_show = 1'b0;
      end else begin
        wn = wrreq && mn.size() < DEPTH;
        rn = rdreq && mn.size() > 0;
        if (rn) begin
          qn_exp   = mn.pop_front();
          qn_known = 1'b1;
        end
        if (wn) mn.push_back(data);

        ws = wrreq && ms.size() < DEPTH;
        rs = rdreq && !empty_s && ms.size() > 0;
        must_show = 1'b0;
        if (rs) begin
          void'(ms.pop_front());
          must_show = ms.size() > 0 && ms[0].wc < cyc_cnt;
        end
        if (ws) ms.push_back('{data, cyc_cnt});
      end
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [W-1:0] d, input bit s = 1'b0);
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = s;
    @(posedge clock);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  initial begin : stim
    int wp, rp;
    wp = 50;
    rp = 50;
    #1 aclr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_usedw", usedw_n, 0);
    check("rst_empty", empty_n, 1);
    check("rst_full", full_n, 0);
    check("rst_almost_empty", ae_n, 1);
    check("rst_almost_full", af_n, 0);
    check("rst_s_empty", empty_s, 1);
    aclr = 1'b1;
    cyc(0, 0, '0);

    // Fill to capacity, probing the thresholds on the way.
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 0, W'(i));
      if (i == 1)  check("ae_at_1", ae_n, 1);
      if (i == 2)  check("ae_at_2", ae_n, 0);
      if (i == 11) check("af_at_11", af_n, 0);
      if (i == 12) check("af_at_12", af_n, 1);
    end
    check("fill_full", full_n, 1);
    check("fill_usedw", usedw_n, 15);
    check("fill_s_usedw", usedw_s, 15);
    check("fill_s_full", full_s, 1);
    cyc(1, 0, W'('h99));
    check("overflow_usedw", usedw_n, 15);
    check("overflow_s_usedw", usedw_s, 15);

    // Drain in order; normal-mode q follows each read by one cycle.
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 1, '0);
      check("drain_q", q_n, i);
    end
    check("drain_empty", empty_n, 1);
    check("drain_usedw", usedw_n, 0);
    check("drain_s_empty", empty_s, 1);
    cyc(0, 1, '0);
    check("underflow_usedw", usedw_n, 0);

    // Show-ahead: a single word must appear within 3 cycles.
    cyc(1, 0, W'('hA5));
    for (int k = 0; k < 3 && empty_s; k++) cyc(0, 0, '0);
    check("sa_empty", empty_s, 0);
    check("sa_q", q_s, 'hA5);
    cyc(0, 1, '0);
    check("sa_empty_after_rd", empty_s, 1);

    // Steady state at usedw=5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1, 0, W'(100 + i));
    cyc(0, 0, '0);
    for (int j = 0; j < 20; j++) begin
      cyc(1, 1, W'(200 + j));
      check("wrap_usedw", usedw_n, 5);
      check("wrap_s_usedw", usedw_s, 5);
      check("wrap_q", q_n, (j < 5) ? 100 + j : 200 + j - 5);
    end

    // Asynchronous reset at usedw=7 takes effect immediately.
    cyc(1, 0, W'(300));
    cyc(1, 0, W'(301));
    check("pre_aclr_usedw", usedw_n, 7);
    aclr = 1'b0;
    #2;
    check("aclr_usedw", usedw_n, 0);
    check("aclr_empty", empty_n, 1);
    check("aclr_full", full_n, 0);
    check("aclr_s_usedw", usedw_s, 0);
    check("aclr_s_empty", empty_s, 1);
    @(posedge clock);
    #1;
    aclr = 1'b1;

    // Synchronous clear at usedw=7 wins over simultaneous requests.
    for (int i = 0; i < 7; i++) cyc(1, 0, W'(400 + i));
    check("pre_sclr_usedw", usedw_n, 7);
    cyc(1, 1, W'('h55), 1'b1);
    check("sclr_usedw", usedw_n, 0);
    check("sclr_empty", empty_n, 1);
    check("sclr_full", full_n, 0);
    check("sclr_s_usedw", usedw_s, 0);
    check("sclr_s_empty", empty_s, 1);

    // Random traffic with shifting write/read bias and rare clears.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
          W'($urandom), $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
